// File: rtl/dmem_mmio_pkg.sv
// rtl/dmem_mmio_pkg.sv - shared constants and address decode for the dmem_mmio data-side responder
// Optional TPRE decode is enabled by MMIO_PRESCALER_EN.
package dmem_mmio_pkg;

    localparam int DATA_W = 32;

    localparam logic [3:0]  RAM_TAG    = 4'h0;
    localparam logic [31:0] MMIO_BASE  = 32'hFFFF_0000;
    localparam logic [31:0] OFF_LED    = 32'h0000_0000;
    localparam logic [31:0] OFF_TCTRL  = 32'h0000_0004;
    localparam logic [31:0] OFF_TLOAD  = 32'h0000_0008;
    localparam logic [31:0] OFF_TCOUNT = 32'h0000_000C;
    localparam logic [31:0] OFF_TSTAT  = 32'h0000_0010;
    localparam logic [31:0] OFF_TPRE   = 32'h0000_0014;

    localparam int TCTRL_EN     = 0;
    localparam int TCTRL_RELOAD = 1;
    localparam int TCTRL_IRQEN  = 2;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_RAM,
        SEL_LED,
        SEL_TCTRL,
        SEL_TLOAD,
        SEL_TCOUNT,
        SEL_TSTAT,
        SEL_TPRE
    } sel_e;

    // Takes the word address only; byte-lane bits never take part in decode.
    function automatic sel_e decode(input logic [29:0] waddr);
        logic [31:0] word;
        word   = {waddr, 2'b00};
        decode = SEL_NONE;
        if (word[31:28] == RAM_TAG) begin
            decode = SEL_RAM;
        end else begin
            case (word)
                MMIO_BASE + OFF_LED:    decode = SEL_LED;
                MMIO_BASE + OFF_TCTRL:  decode = SEL_TCTRL;
                MMIO_BASE + OFF_TLOAD:  decode = SEL_TLOAD;
                MMIO_BASE + OFF_TCOUNT: decode = SEL_TCOUNT;
                MMIO_BASE + OFF_TSTAT:  decode = SEL_TSTAT;
`ifdef MMIO_PRESCALER_EN
                MMIO_BASE + OFF_TPRE:   decode = SEL_TPRE;
`endif
                default:                decode = SEL_NONE;
            endcase
        end
    endfunction

endpackage

// File: rtl/dmem_mmio_timer.sv
// rtl/dmem_mmio_timer.sv - down-counting timer with expiry flag, interrupt and optional prescaler
// Prescaler and TPRE register exist only when MMIO_PRESCALER_EN is defined.
module dmem_mmio_timer
    import dmem_mmio_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              ctrl_we_i,
    input  logic              tload_we_i,
    input  logic              tcount_we_i,
    input  logic              tstat_we_i,
`ifdef MMIO_PRESCALER_EN
    input  logic              tpre_we_i,
    output logic [15:0]       tpre_o,
`endif
    output logic [2:0]        ctrl_o,
    output logic [DATA_W-1:0] tload_o,
    output logic [DATA_W-1:0] tcount_o,
    output logic              exp_o,
    output logic              irq_o
);

    logic              en_q, en_d;
    logic              reload_q, reload_d;
    logic              irqen_q, irqen_d;
    logic              exp_q, exp_d;
    logic [DATA_W-1:0] tload_q, tload_d;
    logic [DATA_W-1:0] tcount_q, tcount_d;
    logic              step;

`ifdef MMIO_PRESCALER_EN
    logic [15:0] tpre_q, tpre_d;
    logic [15:0] pre_q, pre_d;

    assign step = en_q && (pre_q == tpre_q);

    always_comb begin
        tpre_d = tpre_we_i ? wdata_i[15:0] : tpre_q;
        if (!en_q || tcount_we_i || step) begin
            pre_d = '0;
        end else begin
            pre_d = pre_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tpre_q <= '0;
            pre_q  <= '0;
        end else begin
            tpre_q <= tpre_d;
            pre_q  <= pre_d;
        end
    end

    assign tpre_o = tpre_q;
`else
    assign step = en_q;
`endif

    // CPU writes are applied last so they override the timer's own update;
    // the expiry set is applied after W1C so a same-cycle clear loses.
    always_comb begin
        en_d     = en_q;
        reload_d = reload_q;
        irqen_d  = irqen_q;
        exp_d    = exp_q;
        tload_d  = tload_q;
        tcount_d = tcount_q;

        if (tstat_we_i && wdata_i[0]) begin
            exp_d = 1'b0;
        end

        if (step) begin
            if (tcount_q != '0) begin
                tcount_d = tcount_q - DATA_W'(1);
            end else begin
                exp_d = 1'b1;
                if (reload_q) begin
                    tcount_d = tload_q;
                end else begin
                    en_d = 1'b0;
                end
            end
        end

        if (ctrl_we_i) begin
            en_d     = wdata_i[TCTRL_EN];
            reload_d = wdata_i[TCTRL_RELOAD];
            irqen_d  = wdata_i[TCTRL_IRQEN];
        end
        if (tload_we_i) begin
            tload_d = wdata_i;
        end
        if (tcount_we_i) begin
            tcount_d = wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q     <= 1'b0;
            reload_q <= 1'b0;
            irqen_q  <= 1'b0;
            exp_q    <= 1'b0;
            tload_q  <= '0;
            tcount_q <= '0;
        end else begin
            en_q     <= en_d;
            reload_q <= reload_d;
            irqen_q  <= irqen_d;
            exp_q    <= exp_d;
            tload_q  <= tload_d;
            tcount_q <= tcount_d;
        end
    end

    assign ctrl_o   = {irqen_q, reload_q, en_q};
    assign tload_o  = tload_q;
    assign tcount_o = tcount_q;
    assign exp_o    = exp_q;
    assign irq_o    = exp_q & irqen_q;

endmodule

// File: rtl/dmem_mmio.sv
// rtl/dmem_mmio.sv - data RAM, LED latch and timer MMIO behind the core's data port
// Build with MMIO_PRESCALER_EN to add the TPRE register and timer prescaler.
module dmem_mmio
    import dmem_mmio_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int LED_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] writedata,
    input  logic              memwrite,
    output logic [DATA_W-1:0] readdata,
    output logic [LED_W-1:0]  led,
    output logic              irq
);

    sel_e              sel;
    logic [ADDR_W-1:0] ram_idx;
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [LED_W-1:0]  led_q, led_d;
    logic [2:0]        tctrl;
    logic [DATA_W-1:0] tload;
    logic [DATA_W-1:0] tcount;
    logic              texp;
    logic              unused_byte_lane;

    assign sel              = decode(addr[31:2]);
    assign ram_idx          = addr[ADDR_W+1:2];
    assign unused_byte_lane = ^addr[1:0];

    // RAM is deliberately unreset; software must initialise what it reads.
    always_ff @(posedge clk) begin
        if (memwrite && sel == SEL_RAM) begin
            mem[ram_idx] <= writedata;
        end
    end

    assign led_d = (memwrite && sel == SEL_LED) ? writedata[LED_W-1:0] : led_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q <= '0;
        end else begin
            led_q <= led_d;
        end
    end

    assign led = led_q;

`ifdef MMIO_PRESCALER_EN
    logic [15:0] tpre;
`endif

    dmem_mmio_timer u_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .wdata_i     (writedata),
        .ctrl_we_i   (memwrite && sel == SEL_TCTRL),
        .tload_we_i  (memwrite && sel == SEL_TLOAD),
        .tcount_we_i (memwrite && sel == SEL_TCOUNT),
        .tstat_we_i  (memwrite && sel == SEL_TSTAT),
`ifdef MMIO_PRESCALER_EN
        .tpre_we_i   (memwrite && sel == SEL_TPRE),
        .tpre_o      (tpre),
`endif
        .ctrl_o      (tctrl),
        .tload_o     (tload),
        .tcount_o    (tcount),
        .exp_o       (texp),
        .irq_o       (irq)
    );

    always_comb begin
        readdata = '0;
        case (sel)
            SEL_RAM:    readdata = mem[ram_idx];
            SEL_LED:    readdata = DATA_W'(led_q);
            SEL_TCTRL:  readdata = DATA_W'(tctrl);
            SEL_TLOAD:  readdata = tload;
            SEL_TCOUNT: readdata = tcount;
            SEL_TSTAT:  readdata = DATA_W'(texp);
`ifdef MMIO_PRESCALER_EN
            SEL_TPRE:   readdata = DATA_W'(tpre);
`endif
            default:    readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_dmem_mmio.sv
// tb/tb_dmem_mmio.sv - self-checking bench for dmem_mmio (directed scenarios plus randomized traffic)
// Prescaler scenario follows MMIO_PRESCALER_EN.
module tb_dmem_mmio;

    localparam int ADDR_W = 8;
    localparam int LED_W  = 8;
    localparam logic [31:0] A_LED    = 32'hFFFF_0000;
    localparam logic [31:0] A_TCTRL  = 32'hFFFF_0004;
    localparam logic [31:0] A_TLOAD  = 32'hFFFF_0008;
    localparam logic [31:0] A_TCOUNT = 32'hFFFF_000C;
    localparam logic [31:0] A_TSTAT  = 32'hFFFF_0010;
    localparam logic [31:0] A_TPRE   = 32'hFFFF_0014;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [31:0]      addr;
    logic [31:0]      writedata;
    logic             memwrite;
    logic [31:0]      readdata;
    logic [LED_W-1:0] led;
    logic             irq;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state kept at register level, independent of the DUT structure.
    logic [31:0]      m_ram [2**ADDR_W];
    logic [LED_W-1:0] m_led;
    bit               m_en, m_reload, m_irqen, m_exp;
    logic [31:0]      m_tload, m_tcount;
    logic [15:0]      m_tpre;
    int               m_pre;

    always #5 clk = ~clk;

    dmem_mmio #(.ADDR_W(ADDR_W), .LED_W(LED_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .addr      (addr),
        .writedata (writedata),
        .memwrite  (memwrite),
        .readdata  (readdata),
        .led       (led),
        .irq       (irq)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (a[31:28] == 4'h0) return m_ram[a[ADDR_W+1:2]];
        case (w)
            A_LED:    return 32'(m_led);
            A_TCTRL:  return {29'd0, m_irqen, m_reload, m_en};
            A_TLOAD:  return m_tload;
            A_TCOUNT: return m_tcount;
            A_TSTAT:  return {31'd0, m_exp};
`ifdef MMIO_PRESCALER_EN
            A_TPRE:   return {16'd0, m_tpre};
`endif
            default:  return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_led = '0; m_en = 0; m_reload = 0; m_irqen = 0; m_exp = 0;
        m_tload = '0; m_tcount = '0; m_tpre = '0; m_pre = 0;
    endtask

    task automatic model_edge(input logic [31:0] a, input logic [31:0] wd, input bit we);
        logic [31:0] w, cnt;
        bit tick, expire, en, ex, mmio;
        w = {a[31:2], 2'b00};
        mmio = (a[31:28] != 4'h0);
        cnt = m_tcount; en = m_en; ex = m_exp; expire = 0;
`ifdef MMIO_PRESCALER_EN
        tick = m_en && (m_pre == int'(m_tpre));
        if (!m_en || tick || (we && mmio && w == A_TCOUNT)) m_pre = 0;
        else m_pre = m_pre + 1;
`else
        tick = m_en;
`endif
        if (tick) begin
            if (m_tcount > 0) cnt = m_tcount - 1;
            else begin
                expire = 1;
                if (m_reload) cnt = m_tload;
                else en = 0;
            end
        end
        if (we) begin
            if (!mmio) m_ram[a[ADDR_W+1:2]] = wd;
            else case (w)
                A_LED:    m_led = wd[LED_W-1:0];
                A_TCTRL:  begin en = wd[0]; m_reload = wd[1]; m_irqen = wd[2]; end
                A_TLOAD:  m_tload = wd;
                A_TCOUNT: cnt = wd;
                A_TSTAT:  if (wd[0]) ex = 0;
`ifdef MMIO_PRESCALER_EN
                A_TPRE:   m_tpre = wd[15:0];
`endif
                default: ;
            endcase
        end
        if (expire) ex = 1;
        m_tcount = cnt; m_en = en; m_exp = ex;
    endtask

    task automatic cycle(input logic [31:0] a, input logic [31:0] wd, input bit we);
        addr = a; writedata = wd; memwrite = we;
        @(posedge clk);
        model_edge(a, wd, we);
        @(negedge clk);
        memwrite = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] regs [4];
        regs = '{A_TCTRL, A_TLOAD, A_TCOUNT, A_TSTAT};
        rst_n = 1'b0; addr = '0; writedata = '0; memwrite = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        foreach (regs[i]) begin
            addr = regs[i]; #1;
            n_checks++;
            if (readdata !== 32'd0) $display("FAIL reset_read[%h] got %h want 0", regs[i], readdata);
            else n_pass++;
        end
        n_checks++;
        if (irq !== 1'b0) $display("FAIL reset_irq got %b want 0", irq); else n_pass++;
        n_checks++;
        if (led !== '0) $display("FAIL reset_led got %h want 0", led); else n_pass++;
    endtask

    task automatic test_ram();
        cycle(32'h0000_0040, 32'hDEAD_BEEF, 1'b1);
        addr = 32'h0000_0040; #1;
        n_checks++;
        if (readdata !== 32'hDEAD_BEEF) $display("FAIL ram_rd40 got %h want deadbeef", readdata); else n_pass++;
        cycle(32'h0000_0044, 32'd1, 1'b1);
        addr = 32'h0000_0044; #1;
        n_checks++;
        if (readdata !== 32'd1) $display("FAIL ram_rd44 got %h want 1", readdata); else n_pass++;
        addr = 32'h8000_0000; #1;
        n_checks++;
        if (readdata !== 32'd0) $display("FAIL unmapped_8000 got %h want 0", readdata); else n_pass++;
        addr = 32'h0FF0_0040; #1;
        n_checks++;
        if (readdata !== 32'hDEAD_BEEF) $display("FAIL ram_alias got %h want deadbeef", readdata); else n_pass++;
        for (int i = 0; i < 2**ADDR_W; i++) begin
            cycle(32'(i) << 2, $urandom(), 1'b1);
        end
        for (int i = 0; i < 64; i++) begin
            logic [31:0] a;
            a = $urandom() & 32'h0FFF_FFFF;
            addr = a; #1;
            n_checks++;
            if (readdata !== m_read(a)) $display("FAIL ram_rand[%h] got %h want %h", a, readdata, m_read(a));
            else n_pass++;
        end
    endtask

    task automatic test_led();
        cycle(A_LED, 32'h0000_01A5, 1'b1);
        n_checks++;
        if (led !== 8'hA5) $display("FAIL led_out got %h want a5", led); else n_pass++;
        addr = A_LED; #1;
        n_checks++;
        if (readdata !== 32'h0000_00A5) $display("FAIL led_read got %h want a5", readdata); else n_pass++;
        cycle(32'hFFFF_0018, 32'hFFFF_FFFF, 1'b1);
        addr = 32'hFFFF_0018; #1;
        n_checks++;
        if (readdata !== 32'd0) $display("FAIL unmapped_0018 got %h want 0", readdata); else n_pass++;
        cycle(A_TCTRL, 32'hFFFF_FFF8, 1'b1);
        addr = A_TCTRL; #1;
        n_checks++;
        if (readdata !== 32'd0) $display("FAIL tctrl_upper got %h want 0", readdata); else n_pass++;
    endtask

    task automatic test_oneshot();
        logic [31:0] want_cnt [5];
        bit          want_irq [5];
        want_cnt = '{32'd2, 32'd1, 32'd0, 32'd0, 32'd0};
        want_irq = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        cycle(A_TCOUNT, 32'd3, 1'b1);
        cycle(A_TCTRL, 32'd5, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle(A_TCOUNT, 32'd0, 1'b0);
            #1;
            n_checks++;
            if (readdata !== want_cnt[i] || irq !== want_irq[i])
                $display("FAIL oneshot_step%0d got cnt=%0d irq=%b want cnt=%0d irq=%b", i, readdata, irq, want_cnt[i], want_irq[i]);
            else n_pass++;
        end
        addr = A_TCTRL; #1;
        n_checks++;
        if (readdata !== 32'd4) $display("FAIL oneshot_en_clear got %h want 4", readdata); else n_pass++;
        cycle(A_TSTAT, 32'd0, 1'b1);
        n_checks++;
        if (irq !== 1'b1) $display("FAIL w0_no_effect got irq=%b want 1", irq); else n_pass++;
        cycle(A_TSTAT, 32'd1, 1'b1);
        n_checks++;
        if (irq !== 1'b0) $display("FAIL w1c_irq got %b want 0", irq); else n_pass++;
        // Expiry would clear EN on the same edge the CPU rewrites TCTRL.
        cycle(A_TCOUNT, 32'd0, 1'b1);
        cycle(A_TCTRL, 32'd1, 1'b1);
        cycle(A_TCTRL, 32'd1, 1'b1);
        addr = A_TCTRL; #1;
        n_checks++;
        if (readdata !== 32'd1) $display("FAIL tctrl_write_wins got %h want 1", readdata); else n_pass++;
        addr = A_TSTAT; #1;
        n_checks++;
        if (readdata !== 32'd1) $display("FAIL oneshot2_exp got %h want 1", readdata); else n_pass++;
        cycle(A_TCTRL, 32'd0, 1'b1);
        cycle(A_TSTAT, 32'd1, 1'b1);
    endtask

    task automatic test_reload();
        int          op [12];
        logic [31:0] want_cnt [12];
        logic [31:0] want_exp [12];
        op       = '{0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 2, 0};
        want_cnt = '{4, 3, 2, 1, 0, 4, 3, 2, 1, 0, 10, 9};
        want_exp = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1};
        cycle(A_TLOAD, 32'd4, 1'b1);
        cycle(A_TCOUNT, 32'd0, 1'b1);
        cycle(A_TCTRL, 32'd3, 1'b1);
        for (int i = 0; i < 12; i++) begin
            case (op[i])
                1:       cycle(A_TSTAT, 32'd1, 1'b1);
                2:       cycle(A_TCOUNT, 32'd10, 1'b1);
                default: cycle(A_TCOUNT, 32'd0, 1'b0);
            endcase
            addr = A_TCOUNT; #1;
            n_checks++;
            if (readdata !== want_cnt[i]) $display("FAIL reload_cnt%0d got %0d want %0d", i, readdata, want_cnt[i]);
            else n_pass++;
            addr = A_TSTAT; #1;
            n_checks++;
            if (readdata !== want_exp[i]) $display("FAIL reload_exp%0d got %0d want %0d", i, readdata, want_exp[i]);
            else n_pass++;
        end
        cycle(A_TCTRL, 32'd0, 1'b1);
        cycle(A_TSTAT, 32'd1, 1'b1);
    endtask

    task automatic test_prescaler();
`ifdef MMIO_PRESCALER_EN
        cycle(A_TPRE, 32'd2, 1'b1);
        cycle(A_TCOUNT, 32'd2, 1'b1);
        cycle(A_TCTRL, 32'd1, 1'b1);
        for (int i = 1; i <= 9; i++) begin
            cycle(A_TSTAT, 32'd0, 1'b0);
            #1;
            n_checks++;
            if (readdata !== 32'(i == 9)) $display("FAIL prescale_exp@%0d got %0d want %0d", i, readdata, (i == 9));
            else n_pass++;
        end
        cycle(A_TSTAT, 32'd1, 1'b1);
        cycle(A_TPRE, 32'd0, 1'b1);
`else
        cycle(A_TPRE, 32'hFFFF_FFFF, 1'b1);
        addr = A_TPRE; #1;
        n_checks++;
        if (readdata !== 32'd0) $display("FAIL tpre_absent got %h want 0", readdata); else n_pass++;
`endif
    endtask

    task automatic test_async_reset();
        cycle(A_LED, 32'h3C, 1'b1);
        cycle(A_TCOUNT, 32'd100, 1'b1);
        cycle(A_TCTRL, 32'd7, 1'b1);
        repeat (3) cycle(A_TCOUNT, 32'd0, 1'b0);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (readdata !== 32'd0 || led !== '0 || irq !== 1'b0)
            $display("FAIL async_reset got cnt=%0d led=%h irq=%b want 0/0/0", readdata, led, irq);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) cycle(A_TCOUNT, 32'd0, 1'b0);
        #1;
        n_checks++;
        if (readdata !== 32'd0) $display("FAIL no_resume_cnt got %0d want 0", readdata); else n_pass++;
        addr = A_TCTRL; #1;
        n_checks++;
        if (readdata !== 32'd0) $display("FAIL no_resume_ctrl got %h want 0", readdata); else n_pass++;
    endtask

    function automatic logic [31:0] pick_addr(input int k);
        logic [31:0] r;
        r = $urandom();
        case (k)
            0:       return r & 32'h0FFF_FFFF;
            1:       return A_LED | (r & 32'h3);
            2:       return A_TCTRL;
            3:       return A_TLOAD;
            4:       return A_TCOUNT | (r & 32'h3);
            5:       return A_TSTAT;
            6:       return A_TPRE;
            default: return 32'h4000_0000 | (r & 32'h0FFF_FFFF);
        endcase
    endfunction

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a, wd, ra;
            int k;
            bit we;
            k  = $urandom_range(0, 7);
            a  = pick_addr(k);
            wd = (k >= 2 && k <= 6) ? 32'($urandom_range(0, 7)) : $urandom();
            we = ($urandom_range(0, 2) != 0);
            cycle(a, wd, we);
            ra = pick_addr($urandom_range(0, 7));
            addr = ra; #1;
            n_checks++;
            if (readdata !== m_read(ra)) $display("FAIL rand_read%0d[%h] got %h want %h", i, ra, readdata, m_read(ra));
            else n_pass++;
            n_checks++;
            if (irq !== (m_exp & m_irqen) || led !== m_led)
                $display("FAIL rand_out%0d got irq=%b led=%h want irq=%b led=%h", i, irq, led, m_exp & m_irqen, m_led);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_ram();
        test_led();
        test_oneshot();
        test_reload();
        test_prescaler();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
